// File: rtl/pkt_buf_pkg.sv
// Shared constants and write-state encoding for the packet commit buffer.
package pkt_buf_pkg;

   localparam int unsigned ADDR_W_DFLT = 8;
   localparam int unsigned DATA_W_DFLT = 64;
   localparam int unsigned CTRL_W_DFLT = 8;

   localparam logic [7:0] CTRL_DATA = 8'h00;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_HDR  = 2'd1,
      W_BODY = 2'd2,
      W_DROP = 2'd3
   } wstate_t;

endpackage

// File: rtl/pkt_buf_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
module pkt_buf_ram #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned WORD_W = 72
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WORD_W-1:0] o_rdata_c
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/pkt_commit_buffer.sv
// Store-and-forward output stage: only packets whose EOP has been stored are
// released downstream; a packet that overflows the buffer is dropped whole.
module pkt_commit_buffer
   import pkt_buf_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DFLT,
   parameter int unsigned DATA_W     = DATA_W_DFLT,
   parameter int unsigned CTRL_W     = CTRL_W_DFLT,
   parameter int unsigned RDY_THRESH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_wr,
   output logic              in_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_wr,
   input  logic              out_rdy,
   output logic [7:0]        pkt_count,
   output logic [7:0]        drop_count,
   output logic [ADDR_W:0]   used_words
);

   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned WORD_W = CTRL_W + DATA_W;

   wstate_t           r_state;
   logic              r_drop_body;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_commit_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [7:0]        r_pkt_count;
   logic [7:0]        r_drop_count;
   logic              r_out_wr;
   logic [DATA_W-1:0] r_out_data;
   logic [CTRL_W-1:0] r_out_ctrl;

   logic [PTR_W-1:0]  w_used;
   logic [PTR_W-1:0]  w_free;
   logic              w_full;
   logic              w_is_ctrl;
   logic              w_eop;
   logic              w_we;
   logic              w_rd_en;
   logic [WORD_W-1:0] w_rdata;

   // MSB of the pointers separates full (used == DEPTH) from empty.
   assign w_used    = r_wr_ptr - r_rd_ptr;
   assign w_free    = PTR_W'(DEPTH) - w_used;
   assign w_full    = (w_used == PTR_W'(DEPTH));
   assign w_is_ctrl = (in_ctrl != CTRL_W'(CTRL_DATA));
   assign w_eop     = w_is_ctrl && (r_state == W_BODY);
   assign w_we      = in_wr && !w_full && (r_state != W_DROP);
   assign w_rd_en   = out_rdy && (r_rd_ptr != r_commit_ptr);

   assign in_rdy     = (w_free >= PTR_W'(RDY_THRESH)) && (r_state != W_DROP);
   assign used_words = w_used;
   assign out_wr     = r_out_wr;
   assign out_data   = r_out_data;
   assign out_ctrl   = r_out_ctrl;
   assign pkt_count  = r_pkt_count;
   assign drop_count = r_drop_count;

   pkt_buf_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_ram (
      .clk       (clk),
      .i_we      (w_we),
      .i_waddr   (r_wr_ptr[ADDR_W-1:0]),
      .i_wdata   ({in_ctrl, in_data}),
      .i_raddr   (r_rd_ptr[ADDR_W-1:0]),
      .o_rdata_c (w_rdata)
   );

   // Write side: framing FSM, write/commit pointers and counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= W_IDLE;
         r_drop_body  <= 1'b0;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_pkt_count  <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_we) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         case (r_state)
            W_IDLE, W_HDR, W_BODY: begin
               if (in_wr) begin
                  if (w_full) begin
                     // Rewind to the last commit; an overflowing EOP ends the drop at once.
                     r_wr_ptr     <= r_commit_ptr;
                     r_drop_count <= r_drop_count + 8'd1;
                     if (w_eop) begin
                        r_state <= W_IDLE;
                     end else begin
                        r_state     <= W_DROP;
                        r_drop_body <= (r_state == W_BODY) || !w_is_ctrl;
                     end
                  end else if (w_eop) begin
                     r_commit_ptr <= r_wr_ptr + PTR_W'(1);
                     r_pkt_count  <= r_pkt_count + 8'd1;
                     r_state      <= W_IDLE;
                  end else if (w_is_ctrl) begin
                     r_state <= W_HDR;
                  end else begin
                     r_state <= W_BODY;
                  end
               end
            end
            W_DROP: begin
               // Leading header words of a dropped packet are not its EOP.
               if (in_wr) begin
                  if (!w_is_ctrl)       r_drop_body <= 1'b1;
                  else if (r_drop_body) r_state     <= W_IDLE;
               end
            end
            default: r_state <= W_IDLE;
         endcase
      end
   end

   // Read side: forward committed words only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr   <= '0;
         r_out_wr   <= 1'b0;
         r_out_data <= '0;
         r_out_ctrl <= '0;
      end else begin
         r_out_wr <= w_rd_en;
         if (w_rd_en) begin
            {r_out_ctrl, r_out_data} <= w_rdata;
            r_rd_ptr                 <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pkt_commit_buffer.sv
// Directed bench for pkt_commit_buffer with hand-computed expectations.
module tb_pkt_commit_buffer;

   logic        clk;
   logic        reset;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy;
   logic [7:0]  pkt_count;
   logic [7:0]  drop_count;
   logic [8:0]  used_words;

   int errors = 0;
   int checks = 0;

   logic [71:0] got_q [$];
   logic [71:0] exp_q [$];

   pkt_commit_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .in_wr      (in_wr),
      .in_rdy     (in_rdy),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .out_wr     (out_wr),
      .out_rdy    (out_rdy),
      .pkt_count  (pkt_count),
      .drop_count (drop_count),
      .used_words (used_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_wr) got_q.push_back({out_ctrl, out_data});
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] c, input logic [63:0] d);
      in_ctrl = c;
      in_data = d;
      in_wr   = 1'b1;
      @(posedge clk);
      #1;
      in_wr   = 1'b0;
   endtask

   // n-word packet: header FF, n-2 body words, EOP 01; data = base + index.
   task automatic send_pkt(input int n, input logic [63:0] base);
      logic [7:0] c;
      for (int i = 0; i < n; i++) begin
         c = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h01 : 8'h00);
         exp_q.push_back({c, base + 64'(i)});
         send(c, base + 64'(i));
      end
   endtask

   task automatic check_stream(input string tag);
      int bad;
      bad = 0;
      chk({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      chk({tag, "_bad_words"}, 72'(bad), 72'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [71:0] last_w;
      logic [7:0]  c;
      int          rem;
      int          idx;
      logic        rdy;

      reset   = 1'b0;
      in_data = '0;
      in_ctrl = '0;
      in_wr   = 1'b0;
      out_rdy = 1'b0;
      tick(2);

      // Reset state
      chk("rst_out_wr",   72'(out_wr),     72'd0);
      chk("rst_out_word", {out_ctrl, out_data}, 72'd0);
      chk("rst_pkt",      72'(pkt_count),  72'd0);
      chk("rst_drop",     72'(drop_count), 72'd0);
      chk("rst_used",     72'(used_words), 72'd0);
      chk("rst_in_rdy",   72'(in_rdy),     72'd1);
      reset = 1'b1;
      tick(1);

      // Single packet, out_rdy high: 5 consecutive words after the EOP edge
      out_rdy = 1'b1;
      send(8'hFF, 64'd1);
      send(8'h00, 64'd2);
      send(8'h00, 64'd3);
      send(8'h00, 64'd4);
      chk("t1_pre_used", 72'(used_words), 72'd4);
      send(8'h01, 64'd5);
      chk("t1_eop_edge_wr", 72'(out_wr), 72'd0);
      chk("t1_pkt", 72'(pkt_count), 72'd1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         c = (i == 0) ? 8'hFF : ((i == 4) ? 8'h01 : 8'h00);
         chk("t1_wr", 72'(out_wr), 72'd1);
         chk("t1_word", {out_ctrl, out_data}, {c, 64'(i + 1)});
      end
      tick(1);
      chk("t1_wr_after", 72'(out_wr), 72'd0);
      chk("t1_hold", {out_ctrl, out_data}, {8'h01, 64'd5});
      chk("t1_drop", 72'(drop_count), 72'd0);
      chk("t1_used", 72'(used_words), 72'd0);

      // Backpressure: out_rdy toggles 1,0
      do_reset();
      out_rdy = 1'b0;
      send_pkt(5, 64'h11);
      rem    = 5;
      idx    = 0;
      last_w = '0;
      for (int i = 0; i < 12; i++) begin
         rdy     = (i % 2 == 0);
         out_rdy = rdy;
         tick(1);
         if (rdy && rem > 0) begin
            chk("t2_wr", 72'(out_wr), 72'd1);
            chk("t2_word", {out_ctrl, out_data}, exp_q[idx]);
            last_w = exp_q[idx];
            idx++;
            rem--;
         end else begin
            chk("t2_idle", 72'(out_wr), 72'd0);
            if (idx > 0) chk("t2_hold", {out_ctrl, out_data}, last_w);
         end
      end
      check_stream("t2");
      chk("t2_pkt", 72'(pkt_count), 72'd1);

      // Partial packet is held until its EOP
      do_reset();
      out_rdy = 1'b1;
      exp_q.push_back({8'hFF, 64'h21});
      exp_q.push_back({8'h00, 64'h22});
      exp_q.push_back({8'h00, 64'h23});
      exp_q.push_back({8'h01, 64'h24});
      send(8'hFF, 64'h21);
      send(8'h00, 64'h22);
      send(8'h00, 64'h23);
      tick(20);
      chk("t3_held_out", 72'(got_q.size()), 72'd0);
      chk("t3_used", 72'(used_words), 72'd3);
      chk("t3_pkt0", 72'(pkt_count), 72'd0);
      send(8'h01, 64'h24);
      tick(8);
      check_stream("t3");
      chk("t3_pkt", 72'(pkt_count), 72'd1);

      // Overflow: 250 committed words, then a 10-word packet overflows
      do_reset();
      out_rdy = 1'b0;
      send_pkt(250, 64'h1000);
      chk("t4_used250", 72'(used_words), 72'd250);
      chk("t4_rdy250", 72'(in_rdy), 72'd1);
      chk("t4_pkt", 72'(pkt_count), 72'd1);
      for (int k = 1; k <= 10; k++) begin
         c = (k == 1) ? 8'hFF : ((k == 10) ? 8'h01 : 8'h00);
         send(c, 64'h9000 + 64'(k));
         chk("t4_used_k", 72'(used_words), (k <= 6) ? 72'(250 + k) : 72'd250);
         chk("t4_rdy_k",  72'(in_rdy), (k <= 2 || k == 10) ? 72'd1 : 72'd0);
         chk("t4_drop_k", 72'(drop_count), (k >= 7) ? 72'd1 : 72'd0);
      end
      chk("t4_pkt_after", 72'(pkt_count), 72'd1);
      chk("t4_none_out", 72'(got_q.size()), 72'd0);
      out_rdy = 1'b1;
      tick(260);
      check_stream("t4");
      chk("t4_used_end", 72'(used_words), 72'd0);
      chk("t4_pkt_end", 72'(pkt_count), 72'd1);
      chk("t4_drop_end", 72'(drop_count), 72'd1);

      // Wrap-around: 40 packets of 17 words streamed back to back
      do_reset();
      out_rdy = 1'b1;
      for (int p = 0; p < 40; p++) send_pkt(17, 64'(p * 17));
      tick(30);
      check_stream("t5");
      chk("t5_pkt", 72'(pkt_count), 72'd40);
      chk("t5_drop", 72'(drop_count), 72'd0);
      chk("t5_used", 72'(used_words), 72'd0);

      // Reset mid-packet discards committed and partial contents
      do_reset();
      out_rdy = 1'b0;
      send_pkt(3, 64'h5000);
      send(8'hFF, 64'h5100);
      send(8'h00, 64'h5101);
      chk("t6_pre_pkt", 72'(pkt_count), 72'd1);
      chk("t6_pre_used", 72'(used_words), 72'd5);
      do_reset();
      chk("t6_rst_pkt", 72'(pkt_count), 72'd0);
      chk("t6_rst_drop", 72'(drop_count), 72'd0);
      chk("t6_rst_used", 72'(used_words), 72'd0);
      out_rdy = 1'b1;
      tick(3);
      chk("t6_no_stale", 72'(got_q.size()), 72'd0);
      send_pkt(3, 64'h61);
      tick(6);
      check_stream("t6");
      chk("t6_pkt", 72'(pkt_count), 72'd1);
      chk("t6_drop", 72'(drop_count), 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
